// File: rtl/cache_pkg.sv
// Shared cache parameters, writeback FSM state type and address helper.
package cache_pkg;

    localparam int ADDR_W   = 32;
    localparam int INDEX_W  = 7;
    localparam int BLOCK_W  = 512;
    localparam int OFFSET_W = 6;
    localparam int BEAT_W   = 64;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BEATS    = BLOCK_W / BEAT_W;
    localparam int CNT_W    = $clog2(BEATS);

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_SEND = 2'd1,
        WB_RESP = 2'd2
    } wb_state_e;

    function automatic logic [ADDR_W-1:0] block_addr(
        input logic [TAG_W-1:0]   tag,
        input logic [INDEX_W-1:0] index
    );
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_wb_beat_mux.sv
// Selects the current memory beat out of the latched victim block and flags the final beat.
module cache_wb_beat_mux
    import cache_pkg::*;
(
    input  logic [BLOCK_W-1:0] block_i,
    input  logic [CNT_W-1:0]   cnt_i,
    output logic [BEAT_W-1:0]  beat_o,
    output logic               last_o
);

    // Beat 0 is the least significant BEAT_W bits of the block.
    always_comb begin
        beat_o = block_i[cnt_i*BEAT_W +: BEAT_W];
        last_o = (cnt_i == CNT_W'(BEATS - 1));
    end

endmodule

// File: rtl/cache_writeback_buffer.sv
// One-entry dirty-block writeback buffer: latch victim, burst it to memory, await response.
// Optional snoop compare port enabled by defining CACHE_WB_SNOOP_EN.
module cache_writeback_buffer
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               evict_valid,
    output logic               evict_ready,
    input  logic [TAG_W-1:0]   evict_tag,
    input  logic [INDEX_W-1:0] evict_index,
    input  logic [BLOCK_W-1:0] evict_data,
    output logic               mem_wr_valid,
    input  logic               mem_wr_ready,
    output logic [ADDR_W-1:0]  mem_wr_addr,
    output logic [BEAT_W-1:0]  mem_wr_data,
    output logic               mem_wr_last,
    input  logic               mem_wr_resp_valid,
    input  logic               mem_wr_resp_err,
    output logic               wb_busy,
    output logic               wb_done,
    output logic               wb_err
`ifdef CACHE_WB_SNOOP_EN
    ,
    input  logic [TAG_W-1:0]   snoop_tag,
    input  logic [INDEX_W-1:0] snoop_index,
    output logic               snoop_hit
`endif
);

    wb_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic [BLOCK_W-1:0] block_q, block_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [BEAT_W-1:0]  beat_s;
    logic               beat_last_s;
    logic               send_s;

    cache_wb_beat_mux u_beat_mux (
        .block_i (block_q),
        .cnt_i   (cnt_q),
        .beat_o  (beat_s),
        .last_o  (beat_last_s)
    );

    // Control state, latched victim address and completion pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WB_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            tag_q   <= {TAG_W{1'b0}};
            index_q <= {INDEX_W{1'b0}};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            index_q <= index_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Victim data storage; contents are only meaningful while a block is held.
    always_ff @(posedge clk) begin
        block_q <= block_d;
    end

    // Next-state logic for the IDLE -> SEND -> RESP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        index_d = index_q;
        block_d = block_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (evict_valid) begin
                    tag_d   = evict_tag;
                    index_d = evict_index;
                    block_d = evict_data;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = WB_SEND;
                end else begin
                    state_d = WB_IDLE;
                end
            end
            WB_SEND: begin
                if (mem_wr_ready) begin
                    if (beat_last_s) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = WB_RESP;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = WB_SEND;
                end
            end
            WB_RESP: begin
                if (mem_wr_resp_valid) begin
                    state_d = WB_IDLE;
                    done_d  = 1'b1;
                    err_d   = mem_wr_resp_err;
                end else begin
                    state_d = WB_RESP;
                end
            end
            default: begin
                state_d = WB_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Outputs derive from registered state only, so they are glitch-free per cycle.
    always_comb begin
        send_s       = (state_q == WB_SEND);
        evict_ready  = (state_q == WB_IDLE);
        wb_busy      = (state_q != WB_IDLE);
        mem_wr_valid = send_s;
        mem_wr_last  = send_s & beat_last_s;
        mem_wr_addr  = block_addr(tag_q, index_q);
        wb_done      = done_q;
        wb_err       = err_q;
        if (send_s) begin
            mem_wr_data = beat_s;
        end else begin
            mem_wr_data = {BEAT_W{1'b0}};
        end
    end

`ifdef CACHE_WB_SNOOP_EN
    // Lets the controller stall a refill of a block still draining to memory.
    always_comb begin
        snoop_hit = wb_busy && (snoop_tag == tag_q) && (snoop_index == index_q);
    end
`endif

endmodule

// File: doc/cache_writeback_buffer.md
Name: cache_writeback_buffer

Overview:
- Eviction-side counterpart of the 4-way cache data array. That array accepts full 512-bit blocks from memory on refill; this block sends dirty 512-bit blocks back to memory.
- The controller hands over one victim block (tag, set index, data). The block latches it, then streams it to the memory write port as a fixed-length burst with valid/ready handshakes.
- After the burst it waits for the memory write response, then frees the buffer.
- It holds one block, so the controller can start the refill read while the writeback drains.

Parameters:
- ADDR_W, 32, byte address width.
- INDEX_W, 7, set index width (128 sets).
- BLOCK_W, 512, block width in bits (64 bytes).
- BEAT_W, 64, memory data beat width. Must divide BLOCK_W. BEATS = BLOCK_W/BEAT_W = 8.
- Derived localparams: TAG_W = ADDR_W-INDEX_W-6 = 19; CNT_W = clog2(BEATS).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- evict_valid  in  1  controller offers a victim block.
- evict_ready  out  1  buffer empty; offer accepted when valid&&ready.
- evict_tag  in  TAG_W  victim tag.
- evict_index  in  INDEX_W  victim set.
- evict_data  in  BLOCK_W  victim block; word w = bits [w*32 +: 32].
- mem_wr_valid  out  1  beat valid.
- mem_wr_ready  in  1  memory accepts beat.
- mem_wr_addr  out  ADDR_W  block base address {tag,index,6'b0}; constant for the whole burst.
- mem_wr_data  out  BEAT_W  current beat.
- mem_wr_last  out  1  final beat of burst.
- mem_wr_resp_valid  in  1  memory write completion.
- mem_wr_resp_err  in  1  completion carried an error; qualified by resp_valid.
- wb_busy  out  1  buffer occupied (state != IDLE).
- wb_done  out  1  one-cycle pulse on completion.
- wb_err  out  1  one-cycle pulse with wb_done if the response carried an error.

Behaviour:
- Reset (rst_n low at posedge):
  - state=IDLE, beat counter=0.
  - mem_wr_valid=0, mem_wr_last=0, wb_done=0, wb_err=0, wb_busy=0.
  - mem_wr_addr and mem_wr_data = 0. The data buffer need not be cleared.
  - Reset mid-burst abandons the burst; no done pulse is generated.
- States: IDLE, SEND, RESP.
- IDLE:
  - evict_ready=1.
  - On evict_valid: latch tag, index and data; counter=0; next state SEND.
  - mem_wr_valid rises the cycle after acceptance (1-cycle latency).
- SEND:
  - mem_wr_valid=1.
  - mem_wr_data = buffer[cnt*BEAT_W +: BEAT_W]. Beat 0 holds bits [63:0], i.e. words 0-1, ascending.
  - mem_wr_last = (cnt==BEATS-1).
  - On mem_wr_ready: cnt++. On the last beat, next state RESP and mem_wr_valid drops the next cycle.
  - While valid && !ready, data, addr and last are held stable.
  - A burst takes BEATS accepted beats exactly; back-to-back ready gives 8 consecutive cycles.
- RESP:
  - mem_wr_valid=0.
  - On mem_wr_resp_valid: next state IDLE; wb_done=1 next cycle; wb_err=mem_wr_resp_err registered.
- wb_done/wb_err assert in the first IDLE cycle. evict_ready is also 1 in that cycle, so a new eviction may be accepted in the same cycle as the done pulse.
- mem_wr_resp_valid outside RESP is ignored. This includes a response arriving during SEND.
- evict_valid while busy is not accepted; the controller must hold it.
- On error no retry is made; the buffer is freed. Retry policy belongs to the controller.

Optional Feature:
- Macro: CACHE_WB_SNOOP_EN.
- With the macro defined:
  - Adds inputs snoop_tag [TAG_W-1:0] and snoop_index [INDEX_W-1:0].
  - Adds output snoop_hit, combinational: wb_busy && tag and index match the latched victim.
  - The controller uses snoop_hit to stall a refill read of a block that is still being written back.
- Without the macro: the ports are absent and no compare logic exists.

Decomposition:
- Shared package cache_pkg:
  - ADDR_W, INDEX_W, BLOCK_W, OFFSET_W=6.
  - Derived TAG_W.
  - The wb state enum (IDLE/SEND/RESP).
  - Function block_addr(tag,index) returning {tag,index,6'b0}.
- One natural sub-module: cache_wb_beat_mux. It selects the beat from the buffer by counter and generates last.

Test Plan:
- Basic burst: evict tag=19'h1ABCD, index=7'h05, data word w = 32'hA0000000+w, mem_wr_ready held 1.
  - Required: 8 beats on consecutive cycles; beat0=64'hA0000001_A0000000; beat7=64'hA000000F_A000000E; last only on beat 7.
  - Required: addr = {19'h1ABCD, 7'h05, 6'b0} throughout.
  - Required: a resp 3 cycles later gives wb_done for 1 cycle.
- Backpressure: ready toggles 1,0,0,1,... → each beat is held stable while stalled, no beat is skipped or duplicated, and exactly 8 accepted beats.
- Busy rejection: evict_valid held during SEND → evict_ready=0 until the done cycle. The second block is accepted in the done cycle and its first beat appears the next cycle.
- Error response: resp_valid=1 with resp_err=1 → wb_done=1 and wb_err=1 in the same cycle, then IDLE.
- Reset mid-burst: rst_n=0 after beat 3 → next cycle mem_wr_valid=0, wb_busy=0, no wb_done. A following eviction restarts at beat 0.
- Snoop (CACHE_WB_SNOOP_EN): snoop matching the latched tag/index during SEND gives snoop_hit=1. snoop_hit=0 after done, and 0 on an index mismatch.
